// File: rtl/cart_config_bank_if.sv
// CPU-side select/rq/ack bus for the cartridge configuration register bank.
// The CPU asserts a request and the bank answers with a single o_ack one cycle later.
interface cart_config_bank_if #(
  parameter int DATA_WIDTH = 32
);
  // A request is i_select & (i_read_rq | i_write_rq) sampled on a clock edge. It is
  // answered by o_ack on the next cycle only, together with o_data. There is no
  // back-pressure, so a request held for N cycles receives N acks.
  logic                  i_select;
  logic                  i_read_rq;
  logic                  i_write_rq;
  logic [31:0]           i_address;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ack;
  logic [DATA_WIDTH-1:0] o_data;

  modport master (
    output i_select, i_read_rq, i_write_rq, i_address, i_data,
    input  o_ack, o_data
  );

  modport slave (
    input  i_select, i_read_rq, i_write_rq, i_address, i_data,
    output o_ack, o_data
  );
endinterface

// File: rtl/cart_config_bank.sv
// Cartridge configuration register bank: CPU-writable registers with per-bit write masks,
// restored to defaults on synchronised N64 reset/NMI rising edges.
module cart_config_bank #(
  parameter int                              NUM_REGS     = 4,
  parameter int                              DATA_WIDTH   = 32,
  parameter int                              ADDR_LSB     = 2,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUES = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  WRITE_MASK   = '1,
  parameter logic [NUM_REGS-1:0]             RESTORE_MASK = '1,
  parameter int                              SYNC_STAGES  = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_n64_reset,
  input  logic                           i_n64_nmi,
  input  logic                           i_n64_disabled,
  cart_config_bank_if.slave              bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-1:0]            o_changed,
  output logic                           o_n64_restore
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
  logic                   rst_prev_q, rst_prev_d;
  logic                   nmi_prev_q, nmi_prev_d;
  logic                   ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_REGS-1:0]    changed_q, changed_d;
  logic                   restore_q, restore_d;

  logic                   rst_rise;
  logic                   nmi_rise;
  logic                   evt;
  logic                   req;
  logic                   wr_en;
  logic [IDX_W-1:0]       idx;
  logic                   in_range;
  logic [DATA_WIDTH-1:0]  rd_val;

  always_comb begin
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], i_n64_reset};
    nmi_sync_d = {nmi_sync_q[SYNC_STAGES-2:0], i_n64_nmi};
    // Edge history tracks the synced lines even while disabled, so re-enabling
    // with a line already high does not look like a fresh edge.
    rst_prev_d = rst_sync_q[SYNC_STAGES-1];
    nmi_prev_d = nmi_sync_q[SYNC_STAGES-1];
    rst_rise   = rst_sync_q[SYNC_STAGES-1] & ~rst_prev_q;
    nmi_rise   = nmi_sync_q[SYNC_STAGES-1] & ~nmi_prev_q;
    evt        = ~i_n64_disabled & (rst_rise | nmi_rise);
  end

  always_comb begin
    req      = bus.i_select & (bus.i_read_rq | bus.i_write_rq);
    wr_en    = bus.i_select & bus.i_write_rq;
    idx      = bus.i_address[ADDR_LSB +: IDX_W];
    in_range = (32'(idx) < NUM_REGS);
    rd_val   = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (in_range && (idx == IDX_W'(k))) begin
        rd_val = regs_q[k];
      end
    end
    ack_d     = req;
    rdata_d   = req ? rd_val : '0;
    restore_d = evt;
  end

  always_comb begin
    changed_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (wr_en && in_range && (idx == IDX_W'(k))) begin
        regs_d[k] = (regs_q[k] & ~WRITE_MASK[k*DATA_WIDTH +: DATA_WIDTH])
                  | (bus.i_data & WRITE_MASK[k*DATA_WIDTH +: DATA_WIDTH]);
      end
      // A restore overrides a same-cycle CPU write to a restorable register.
      if (evt && RESTORE_MASK[k]) begin
        regs_d[k] = RESET_VALUES[k*DATA_WIDTH +: DATA_WIDTH];
      end
      changed_d[k] = (regs_d[k] != regs_q[k]);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VALUES[k*DATA_WIDTH +: DATA_WIDTH];
      end
      rst_sync_q <= '0;
      nmi_sync_q <= '0;
      rst_prev_q <= 1'b0;
      nmi_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      changed_q  <= '0;
      restore_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
      rst_sync_q <= rst_sync_d;
      nmi_sync_q <= nmi_sync_d;
      rst_prev_q <= rst_prev_d;
      nmi_prev_q <= nmi_prev_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      changed_q  <= changed_d;
      restore_q  <= restore_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign bus.o_ack     = ack_q;
  assign bus.o_data    = rdata_q;
  assign o_changed     = changed_q;
  assign o_n64_restore = restore_q;

endmodule

// File: tb/tb_cart_config_bank.sv
// Directed bench for cart_config_bank with three registers, word addressing and a
// two-stage N64 synchroniser; expected register state is tracked in exp_r0..exp_r2.
module tb_cart_config_bank;
  localparam int NUM_REGS = 3;
  localparam int DW       = 32;

  logic clk;
  logic rst;
  logic n64_reset;
  logic n64_nmi;
  logic n64_disabled;
  logic [NUM_REGS*DW-1:0] regs;
  logic [NUM_REGS-1:0]    changed;
  logic                   restore;

  int checks;
  int failures;
  int pulse_cnt;
  logic [DW-1:0] exp_r0, exp_r1, exp_r2;

  cart_config_bank_if #(.DATA_WIDTH(DW)) bus ();

  cart_config_bank #(
    .NUM_REGS     (NUM_REGS),
    .DATA_WIDTH   (DW),
    .ADDR_LSB     (2),
    .RESET_VALUES ({32'h0000_0055, 32'h0000_0000, 32'h0000_0001}),
    .WRITE_MASK   ({32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_0003}),
    .RESTORE_MASK (3'b001),
    .SYNC_STAGES  (2)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_n64_reset    (n64_reset),
    .i_n64_nmi      (n64_nmi),
    .i_n64_disabled (n64_disabled),
    .bus            (bus.slave),
    .o_regs         (regs),
    .o_changed      (changed),
    .o_n64_restore  (restore)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_regs();
    return 128'({exp_r2, exp_r1, exp_r0});
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge: drives one request cycle, returns at the negedge of T+1.
  task automatic do_req(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data);
    bus.i_select   = 1'b1;
    bus.i_write_rq = wr;
    bus.i_read_rq  = rd;
    bus.i_address  = addr;
    bus.i_data     = data;
    @(negedge clk);
    bus.i_select   = 1'b0;
    bus.i_write_rq = 1'b0;
    bus.i_read_rq  = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; n64_reset = 1'b0; n64_nmi = 1'b0; n64_disabled = 1'b0;
    bus.i_select = 1'b0; bus.i_read_rq = 1'b0; bus.i_write_rq = 1'b0;
    bus.i_address = '0; bus.i_data = '0;
    exp_r0 = 32'h1; exp_r1 = 32'h0; exp_r2 = 32'h55;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    // reset state
    check_eq("rst_regs", 128'(regs), exp_regs());
    check_eq("rst_ack", 128'(bus.o_ack), 128'(0));
    check_eq("rst_data", 128'(bus.o_data), 128'(0));
    check_eq("rst_changed", 128'(changed), 128'(0));
    check_eq("rst_restore", 128'(restore), 128'(0));

    // masked write to reg0
    do_req(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
    exp_r0 = 32'h3;
    check_eq("wr0_ack", 128'(bus.o_ack), 128'(1));
    check_eq("wr0_regs", 128'(regs), exp_regs());
    check_eq("wr0_changed", 128'(changed), 128'(3'b001));
    cyc(1);
    check_eq("idle_ack", 128'(bus.o_ack), 128'(0));
    check_eq("idle_changed", 128'(changed), 128'(0));
    check_eq("idle_data", 128'(bus.o_data), 128'(0));

    do_req(1'b0, 1'b1, 32'h0, 32'h0);
    check_eq("rd0_ack", 128'(bus.o_ack), 128'(1));
    check_eq("rd0_data", 128'(bus.o_data), 128'(32'h3));
    check_eq("rd0_changed", 128'(changed), 128'(0));

    do_req(1'b1, 1'b0, 32'h4, 32'hAB);
    exp_r1 = 32'hAB;
    check_eq("wr1_regs", 128'(regs), exp_regs());
    check_eq("wr1_changed", 128'(changed), 128'(3'b010));

    // identical data: no change pulse
    do_req(1'b1, 1'b0, 32'h4, 32'hAB);
    check_eq("wr1_same_ack", 128'(bus.o_ack), 128'(1));
    check_eq("wr1_same_changed", 128'(changed), 128'(0));

    // only masked-off bits differ: no change
    do_req(1'b1, 1'b0, 32'h8, 32'h1234_0055);
    check_eq("wr2_masked_regs", 128'(regs), exp_regs());
    check_eq("wr2_masked_changed", 128'(changed), 128'(0));
    do_req(1'b1, 1'b0, 32'h8, 32'hFFFF_1234);
    exp_r2 = 32'h1234;
    check_eq("wr2_regs", 128'(regs), exp_regs());
    check_eq("wr2_changed", 128'(changed), 128'(3'b100));

    // read and write together: write done, old data returned
    do_req(1'b1, 1'b1, 32'h4, 32'h77);
    exp_r1 = 32'h77;
    check_eq("rw_data", 128'(bus.o_data), 128'(32'hAB));
    check_eq("rw_regs", 128'(regs), exp_regs());
    do_req(1'b1, 1'b0, 32'h4, 32'hAB);
    exp_r1 = 32'hAB;

    // out of range index 3
    do_req(1'b1, 1'b0, 32'hC, 32'hDEAD);
    check_eq("oor_wr_ack", 128'(bus.o_ack), 128'(1));
    check_eq("oor_wr_regs", 128'(regs), exp_regs());
    check_eq("oor_wr_changed", 128'(changed), 128'(0));
    do_req(1'b0, 1'b1, 32'hC, 32'h0);
    check_eq("oor_rd_ack", 128'(bus.o_ack), 128'(1));
    check_eq("oor_rd_data", 128'(bus.o_data), 128'(0));

    // held read: one ack per request cycle
    bus.i_select = 1'b1; bus.i_read_rq = 1'b1; bus.i_address = 32'h8;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check_eq("held_ack", 128'(bus.o_ack), 128'(1));
      check_eq("held_data", 128'(bus.o_data), 128'(32'h1234));
    end
    bus.i_select = 1'b0; bus.i_read_rq = 1'b0;
    cyc(1);
    check_eq("held_end_ack", 128'(bus.o_ack), 128'(0));

    // NMI restore, latency SYNC_STAGES+1
    do_req(1'b1, 1'b0, 32'h0, 32'h2);
    exp_r0 = 32'h2;
    check_eq("pre_nmi_regs", 128'(regs), exp_regs());
    n64_nmi = 1'b1;
    cyc(2);
    check_eq("nmi_early_regs", 128'(regs), exp_regs());
    check_eq("nmi_early_restore", 128'(restore), 128'(0));
    cyc(1);
    exp_r0 = 32'h1;
    check_eq("nmi_regs", 128'(regs), exp_regs());
    check_eq("nmi_restore", 128'(restore), 128'(1));
    check_eq("nmi_changed", 128'(changed), 128'(3'b001));
    cyc(1);
    check_eq("nmi_restore_end", 128'(restore), 128'(0));
    n64_nmi = 1'b0;
    cyc(4);

    // restore to current value: pulse, no change
    n64_nmi = 1'b1;
    cyc(3);
    check_eq("nmi_same_restore", 128'(restore), 128'(1));
    check_eq("nmi_same_changed", 128'(changed), 128'(0));
    n64_nmi = 1'b0;
    cyc(4);

    // disabled: toggling reset does nothing; enabling with line high does nothing
    do_req(1'b1, 1'b0, 32'h0, 32'h2);
    exp_r0 = 32'h2;
    n64_disabled = 1'b1;
    pulse_cnt = 0;
    n64_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin cyc(1); if (restore) pulse_cnt++; end
    n64_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(1); if (restore) pulse_cnt++; end
    n64_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin cyc(1); if (restore) pulse_cnt++; end
    n64_disabled = 1'b0;
    for (int i = 0; i < 5; i++) begin cyc(1); if (restore) pulse_cnt++; end
    check_eq("dis_pulses", 128'(pulse_cnt), 128'(0));
    check_eq("dis_regs", 128'(regs), exp_regs());
    n64_reset = 1'b0;
    cyc(4);

    // reset and NMI rising together: one event
    pulse_cnt = 0;
    n64_reset = 1'b1; n64_nmi = 1'b1;
    for (int i = 0; i < 6; i++) begin cyc(1); if (restore) pulse_cnt++; end
    exp_r0 = 32'h1;
    check_eq("both_pulses", 128'(pulse_cnt), 128'(1));
    check_eq("both_regs", 128'(regs), exp_regs());
    n64_reset = 1'b0; n64_nmi = 1'b0;
    cyc(4);

    // collision: write reg0 in the restore cycle
    do_req(1'b1, 1'b0, 32'h0, 32'h2);
    exp_r0 = 32'h2;
    n64_nmi = 1'b1;
    cyc(2);
    do_req(1'b1, 1'b0, 32'h0, 32'h0);
    exp_r0 = 32'h1;
    check_eq("col0_ack", 128'(bus.o_ack), 128'(1));
    check_eq("col0_restore", 128'(restore), 128'(1));
    check_eq("col0_regs", 128'(regs), exp_regs());
    check_eq("col0_changed", 128'(changed), 128'(3'b001));
    n64_nmi = 1'b0;
    cyc(4);

    // collision: write to a non-restorable register still lands
    do_req(1'b1, 1'b0, 32'h0, 32'h2);
    exp_r0 = 32'h2;
    n64_nmi = 1'b1;
    cyc(2);
    do_req(1'b1, 1'b0, 32'h4, 32'h99);
    exp_r0 = 32'h1; exp_r1 = 32'h99;
    check_eq("col1_ack", 128'(bus.o_ack), 128'(1));
    check_eq("col1_regs", 128'(regs), exp_regs());
    check_eq("col1_changed", 128'(changed), 128'(3'b011));
    n64_nmi = 1'b0;
    cyc(2);

    // async reset restores defaults
    rst = 1'b1;
    #1;
    exp_r0 = 32'h1; exp_r1 = 32'h0; exp_r2 = 32'h55;
    check_eq("rst2_regs", 128'(regs), exp_regs());
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check_eq("rst2_ack", 128'(bus.o_ack), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
